alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops and a WIDTH-cycle unsigned
// shift-add multiplier behind a valid/ready handshake on both sides.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic               ovf_reg, ovf_next;
  logic               zero_reg, zero_next;
  logic               neg_reg, neg_next;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_prod;

  // Single-cycle datapath for every opcode except MUL.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      3'd1: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      3'd2: begin
        alu_res = A + B;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      3'd3: begin
        alu_res = A - B;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      3'd4: alu_res = A & B;
      3'd5: alu_res = A | B;
      3'd6: alu_res = ~(A | B);
      3'd7: alu_res = A ^ B;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: the multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    step_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    step_prod = {step_sum, prod_reg[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    prod_next  = prod_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    hi_next    = hi_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;
    neg_next   = neg_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mcand_next = A;
          if (control == 3'd0) begin
            prod_next  = {{WIDTH{1'b0}}, B};
            cnt_next   = '0;
            state_next = BUSY;
          end else begin
            out_next   = alu_res;
            hi_next    = '0;
            ovf_next   = alu_ovf;
            zero_next  = (alu_res == '0);
            neg_next   = alu_res[WIDTH-1];
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        prod_next = step_prod;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          out_next   = step_prod[WIDTH-1:0];
          hi_next    = step_prod[2*WIDTH-1:WIDTH];
          ovf_next   = |step_prod[2*WIDTH-1:WIDTH];
          zero_next  = (step_prod[WIDTH-1:0] == '0);
          neg_next   = step_prod[WIDTH-1];
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      prod_reg  <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      hi_reg    <= '0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      prod_reg  <= prod_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      hi_reg    <= hi_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
      neg_reg   <= neg_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign hi        = hi_reg;
  assign overflow  = ovf_reg;
  assign zero      = zero_reg;
  assign negative  = neg_reg;

endmodule
